// File: rtl/vga_pixel_cmd_writer.sv
// SPI-fed pixel command FIFO that drains into the framebuffer write port.
// Framebuffer writes only happen while the timing generator reports blanking.
module vga_pixel_cmd_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_CELLS  = 1200,
  parameter int ADDR_W     = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  input  logic              active,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        wr_data,
  output logic              fifo_full,
  output logic              busy,
  output logic              cmd_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_CELLS - 1);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;

  logic [1:0]  sck_sync;
  logic [1:0]  mosi_sync;
  logic [1:0]  cs_sync;
  logic        sck_prev;
  logic        sck_rise;
  logic [15:0] shift_reg;
  logic [3:0]  bit_cnt;
  logic        push_pend;

  assign sck_rise = sck_sync[1] & ~sck_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      cs_sync   <= 2'b11;
      sck_prev  <= 1'b0;
      shift_reg <= 16'h0;
      bit_cnt   <= 4'd0;
      push_pend <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], spi_sck};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      sck_prev  <= sck_sync[1];
      push_pend <= 1'b0;
      if (cs_sync[1]) begin
        bit_cnt <= 4'd0;
      end else if (sck_rise) begin
        shift_reg <= {shift_reg[14:0], mosi_sync[1]};
        bit_cnt   <= bit_cnt + 4'd1;
        if (bit_cnt == 4'd15) push_pend <= 1'b1;
      end
    end
  end

  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   cnt_nxt;
  logic             empty;
  logic             pop;
  logic             push_ok;
  logic             drop;

  assign empty   = (count == '0);
  // A push into a full FIFO still lands if the head leaves this cycle.
  assign push_ok = push_pend & (~fifo_full | pop);
  assign drop    = push_pend & ~push_ok;

  always_comb begin
    cnt_nxt = count;
    if (push_ok && !pop) cnt_nxt = count + 1'b1;
    else if (!push_ok && pop) cnt_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shift_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= cnt_nxt;
      fifo_full <= (cnt_nxt == FULL_CNT);
    end
  end

  logic              h_op;
  logic [2:0]        h_col;
  logic [ADDR_W-1:0] h_addr;
  logic              addr_ok;

  assign h_op    = mem[rd_ptr][15];
  assign h_col   = mem[rd_ptr][14:12];
  assign h_addr  = ADDR_W'(mem[rd_ptr][10:0]);
  assign addr_ok = (h_addr <= LAST);

  logic [1:0]        state;
  logic [ADDR_W-1:0] cur_addr;
  logic [2:0]        colour;
  logic [ADDR_W-1:0] last_addr;
  logic [2:0]        last_data;
  logic              bad;

  assign pop = (state == S_IDLE) & ~empty & ~active;
  assign bad = pop & ~h_op & ~addr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cur_addr <= '0;
      colour   <= 3'd0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (pop && h_op) begin
            state    <= S_FILL;
            cur_addr <= '0;
            colour   <= h_col;
          end else if (pop && addr_ok) begin
            state    <= S_WRITE;
            cur_addr <= h_addr;
            colour   <= h_col;
          end
        end
        (state == S_WRITE): begin
          if (!active) state <= S_IDLE;
        end
        default: begin
          if (!active) begin
            if (cur_addr == LAST) state <= S_IDLE;
            else cur_addr <= cur_addr + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr <= '0;
      last_data <= 3'd0;
      cmd_err   <= 1'b0;
    end else begin
      if (wr_en) begin
        last_addr <= cur_addr;
        last_data <= colour;
      end
      if (drop || bad) cmd_err <= 1'b1;
    end
  end

  // Write strobe is gated by active combinationally so it never overlaps video.
  assign wr_en   = (state != S_IDLE) & ~active;
  assign wr_addr = wr_en ? cur_addr : last_addr;
  assign wr_data = wr_en ? colour : last_data;
  assign busy    = (state != S_IDLE) | ~empty;

endmodule

// File: tb/tb_vga_pixel_cmd_writer.sv
// Directed bench for vga_pixel_cmd_writer: SPI words in,
// framebuffer writes logged and compared to hand-computed values.
module tb_vga_pixel_cmd_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        active = 1'b0;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [2:0]  wr_data;
  logic        fifo_full;
  logic        busy;
  logic        cmd_err;

  int vectors = 0;
  int miscompares = 0;
  int n_overlap = 0;
  int mark;
  logic [10:0] la[$];
  logic [2:0]  ld[$];

  vga_pixel_cmd_writer dut (
    .clk(clk),
    .rst_n(rst_n),
    .spi_sck(spi_sck),
    .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n),
    .active(active),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .fifo_full(fifo_full),
    .busy(busy),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      la.push_back(wr_addr);
      ld.push_back(wr_data);
      if (active) n_overlap++;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [15:0] w, input int n);
    for (int i = 15; i > 15 - n; i--) begin
      spi_mosi = w[i];
      #40 spi_sck = 1'b1;
      #40 spi_sck = 1'b0;
    end
  endtask

  task automatic spi_word(input logic [15:0] w);
    spi_cs_n = 1'b0;
    #40;
    spi_bits(w, 16);
    #40 spi_cs_n = 1'b1;
    cycles(10);
  endtask

  task automatic do_reset(input bit chk_in_reset);
    rst_n = 1'b0;
    active = 1'b0;
    repeat (3) begin
      @(posedge clk);
      spi_sck  = 1'($urandom);
      spi_mosi = 1'($urandom);
      spi_cs_n = 1'($urandom);
    end
    @(negedge clk);
    if (chk_in_reset) begin
      check("rst_wr_en", wr_en, 0);
      check("rst_busy", busy, 0);
      check("rst_full", fifo_full, 0);
      check("rst_err", cmd_err, 0);
      check("rst_addr", wr_addr, 0);
    end
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    spi_cs_n = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    cycles(5);
  endtask

  initial begin
    int gaps;
    int badd;
    int w;

    do_reset(1'b1);
    check("post_rst_busy", busy, 0);

    // out-of-range single write, then a valid one
    mark = la.size();
    spi_word(16'h54B3);
    check("oob_writes", la.size() - mark, 0);
    check("oob_err", cmd_err, 1);
    do_reset(1'b0);
    mark = la.size();
    spi_word(16'h3123);
    check("wr_count", la.size() - mark, 1);
    if (la.size() > mark) begin
      check("wr_addr", la[mark], 291);
      check("wr_data", ld[mark], 3);
    end
    check("wr_err", cmd_err, 0);

    // held across active video
    do_reset(1'b0);
    active = 1'b1;
    mark = la.size();
    spi_word(16'h7005);
    check("hold_none", la.size() - mark, 0);
    check("hold_busy", busy, 1);
    active = 1'b0;
    cycles(2);
    check("hold_count", la.size() - mark, 1);
    if (la.size() > mark) begin
      check("hold_addr", la[mark], 5);
      check("hold_data", ld[mark], 7);
    end

    // whole-screen fill spanning several blanking windows
    do_reset(1'b0);
    active = 1'b1;
    n_overlap = 0;
    mark = la.size();
    spi_word(16'hA000);
    w = 0;
    while (w < 40 && busy) begin
      active = (w % 2 == 0) ? 1'b0 : 1'b1;
      cycles(100);
      w++;
    end
    active = 1'b0;
    cycles(5);
    check("fill_count", la.size() - mark, 1200);
    gaps = 0;
    badd = 0;
    for (int i = 0; i < la.size() - mark; i++) begin
      if (la[mark + i] != 11'(i)) gaps++;
      if (ld[mark + i] != 3'd2) badd++;
    end
    check("fill_order", gaps, 0);
    check("fill_data", badd, 0);
    check("fill_overlap", n_overlap, 0);
    check("fill_idle", busy, 0);

    // overflow: three words in one frame, then two more
    do_reset(1'b0);
    active = 1'b1;
    mark = la.size();
    spi_cs_n = 1'b0;
    #40;
    spi_bits(16'h1010, 16);
    spi_bits(16'h2020, 16);
    spi_bits(16'h3030, 16);
    #40 spi_cs_n = 1'b1;
    cycles(10);
    check("ovf_full3", fifo_full, 0);
    spi_word(16'h4040);
    check("ovf_full4", fifo_full, 1);
    check("ovf_err4", cmd_err, 0);
    spi_word(16'h5050);
    check("ovf_err5", cmd_err, 1);
    active = 1'b0;
    cycles(20);
    check("ovf_count", la.size() - mark, 4);
    for (int i = 0; i < 4; i++) begin
      if (la.size() > mark + i) begin
        check("ovf_addr", la[mark + i], 16 * (i + 1));
        check("ovf_data", ld[mark + i], i + 1);
      end
    end
    check("ovf_full_end", fifo_full, 0);

    // aborted partial word is discarded silently
    do_reset(1'b0);
    mark = la.size();
    spi_cs_n = 1'b0;
    #40;
    spi_bits(16'hFFFF, 9);
    #40 spi_cs_n = 1'b1;
    cycles(10);
    spi_word(16'h1001);
    check("abort_count", la.size() - mark, 1);
    if (la.size() > mark) begin
      check("abort_addr", la[mark], 1);
      check("abort_data", ld[mark], 1);
    end
    check("abort_err", cmd_err, 0);

    // reset in the middle of a fill
    do_reset(1'b0);
    mark = la.size();
    spi_word(16'hA000);
    cycles(30);
    check("mid_started", la.size() > mark, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_wr_en", wr_en, 0);
    check("mid_busy", busy, 0);
    check("mid_addr", wr_addr, 0);
    cycles(2);
    rst_n = 1'b1;
    mark = la.size();
    cycles(20);
    check("mid_no_more", la.size() - mark, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_pixel_cmd_writer.md
Name: vga_pixel_cmd_writer

Overview:
- Upstream write-side feeder for the 40x30 framebuffer.
- Receives 16-bit pixel commands from the Arduino over a mode-0 SPI link and buffers them in a small command FIFO.
- Drains the FIFO into the framebuffer write port only while the VGA timing generator reports blanking (active low).
- Supports single-cell writes and a whole-screen fill that pauses across active video and resumes in the next blanking window.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.
- NUM_CELLS, 1200, framebuffer cells (40x30); valid addresses are 0..NUM_CELLS-1.
- ADDR_W, 11, framebuffer address width.

Ports:
- clk  input  1  system/pixel clock.
- rst_n  input  1  asynchronous active-low reset.
- spi_sck  input  1  Arduino SPI clock; asynchronous to clk.
- spi_mosi  input  1  Arduino SPI data; asynchronous to clk.
- spi_cs_n  input  1  Arduino SPI chip select, active low; asynchronous to clk.
- active  input  1  active-video flag from the timing generator; writes are forbidden while it is high.
- wr_en  output  1  framebuffer write strobe.
- wr_addr  output  ADDR_W  framebuffer write address (y*40+x).
- wr_data  output  3  framebuffer write colour {r,g,b}.
- fifo_full  output  1  command FIFO full.
- busy  output  1  engine not IDLE, or FIFO non-empty.
- cmd_err  output  1  sticky: an address was out of range or the FIFO overflowed; cleared only by reset.

Behaviour:
- Reset: all outputs are 0; FIFO is empty; shift register and bit counter are 0; FSM is IDLE.
- Synchronisers: spi_sck, spi_mosi and spi_cs_n each pass through 2-flop synchronisers. The sck rising edge is detected on the synchronised signal. clk must be at least 4x sck.
- Receiver:
  - While synchronised cs_n is low, each sck rising edge shifts mosi into a 16-bit register, MSB first, and increments a 4-bit counter.
  - On the 16th bit the word is pushed to the FIFO on the following clk cycle and the counter returns to 0.
  - Synchronised cs_n high clears the counter; a partial word is discarded with no error.
  - Back-to-back words within one cs_n low period are allowed.
- Command word:
  - bit15 is the opcode: 0 = WRITE, 1 = FILL.
  - bits14:12 are the colour.
  - bit11 is reserved and ignored.
  - bits10:0 are the address; ignored for FILL.
- FIFO:
  - Synchronous, first-word fall-through.
  - A push while full drops the word and sets cmd_err.
  - A simultaneous push and pop when full is accepted.
  - fifo_full is registered and asserts in the cycle after the push that fills the FIFO.
- FSM states: IDLE, WRITE, FILL.
- IDLE:
  - If the FIFO is non-empty and active=0, pop the head entry.
  - WRITE with address < NUM_CELLS: go to WRITE.
  - WRITE with address >= NUM_CELLS: drop it, set cmd_err, stay IDLE.
  - FILL: load fill_addr=0 and the colour, then go to FILL.
- WRITE:
  - Assert wr_en for exactly one cycle with the latched address and colour, then return to IDLE.
  - Latency from pop to wr_en is 1 cycle.
- FILL:
  - Each cycle with active=0: wr_en=1, wr_addr=fill_addr, wr_data=colour, then fill_addr+1.
  - Each cycle with active=1: wr_en=0 and fill_addr holds.
  - After writing NUM_CELLS-1, return to IDLE.
  - The FIFO is not popped during FILL; it keeps accepting pushes.
- Blanking guard:
  - wr_en is combinationally gated by ~active, so no write ever coincides with active=1.
  - A WRITE whose strobe cycle sees active=1 holds in WRITE until active=0.
- Idle outputs: wr_addr and wr_data hold their last values when wr_en=0.
- Reset mid-operation: FIFO, fill progress and the partial SPI word are all discarded; outputs return to reset values immediately.

Test Plan:
- Reset: hold rst_n low for 3 clocks with random SPI activity -> wr_en=0, busy=0, fifo_full=0, cmd_err=0.
- Single write: active=0, send 0x5000 | 0x04B3 (colour 5, addr 1203) -> no wr_en, cmd_err=1. Then send 0x3123 (colour 3, addr 0x123=291) -> exactly one wr_en pulse with wr_addr=291, wr_data=3'b011.
- Blanking hold: active=1 throughout, send 0x7005 -> no wr_en, busy=1. Drop active -> one wr_en with addr 5 and data 7 within 2 clocks.
- Fill across active: send 0xA000 (FILL, colour 2) and toggle active in 100-cycle windows -> exactly 1200 wr_en pulses, addresses 0..1199 ascending with no gaps or repeats, none while active=1, data=3'b010.
- Overflow: active=1, send 5 WRITE words -> fifo_full=1 after the 4th word, cmd_err=1 after the 5th. Drop active -> exactly 4 writes, in order.
- Aborted word: raise cs_n after 9 bits, then send 0x1001 -> exactly one write with addr 1 and data 1; cmd_err stays 0.
